// File: rtl/atomrvcore_dccm_lsu.sv
// DCCM with RV32 load/store unit for the memory stage; registered writeback bundle.
// Optional feature: define DCCM_MISALIGN_TRAP_EN to trap misaligned/illegal accesses on err_o.
module atomrvcore_dccm_lsu #(
   parameter int unsigned DATAWIDTH        = 32,
   parameter int unsigned ADDRESS_BUS      = 10,
   parameter int unsigned REG_ADRESS_WIDTH = 5,
   parameter int unsigned READ_LATENCY     = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   input  logic [DATAWIDTH-1:0]        address_i,
   input  logic                        DWR_EN_i,
   input  logic                        DR_EN_i,
   input  logic [2:0]                  funct3_i,
   input  logic [DATAWIDTH-1:0]        DT_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
   input  logic                        RWR_EN_i,
   input  logic [DATAWIDTH-1:0]        result_i,
   output logic                        stall_o,
   output logic                        wb_valid_o,
   output logic                        RWR_EN_o,
   output logic [REG_ADRESS_WIDTH-1:0] RD_o,
   output logic [DATAWIDTH-1:0]        WR_o,
   output logic                        err_o
);

   localparam logic [0:0]  ST_IDLE = 1'b0;
   localparam logic [0:0]  ST_LOAD = 1'b1;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned DEPTH   = 2 ** ADDRESS_BUS;

   logic [DATAWIDTH-1:0]        mem [DEPTH];

   logic [0:0]                  state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [ADDRESS_BUS-1:0]      ld_idx_q, ld_idx_d;
   logic [1:0]                  ld_ofs_q, ld_ofs_d;
   logic [2:0]                  ld_f3_q, ld_f3_d;
   logic [REG_ADRESS_WIDTH-1:0] ld_rd_q, ld_rd_d;
   logic                        ld_rwr_q, ld_rwr_d;
   logic                        wb_valid_q, wb_valid_d;
   logic                        rwr_en_q, rwr_en_d;
   logic [REG_ADRESS_WIDTH-1:0] rd_q, rd_d;
   logic [DATAWIDTH-1:0]        wr_q, wr_d;
   logic                        err_q, err_d;

   logic [ADDRESS_BUS-1:0]      idx_c;
   logic [1:0]                  ofs_c;
   logic                        trap_c;
   logic                        mem_we_c;
   logic [3:0]                  be_c;
   logic [DATAWIDTH-1:0]        wdata_c;
   logic [DATAWIDTH-1:0]        rdata_c;
   logic [DATAWIDTH-1:0]        shifted_c;
   logic [15:0]                 half_c;
   logic [DATAWIDTH-1:0]        load_data_c;
   logic                        unused_addr_c;

   assign idx_c         = address_i[ADDRESS_BUS+1:2];
   assign ofs_c         = address_i[1:0];
   assign unused_addr_c = ^address_i[DATAWIDTH-1:ADDRESS_BUS+2];

   // funct3[1:0]: 00 byte, 01 half, anything else handled as word
`ifdef DCCM_MISALIGN_TRAP_EN
   logic legal_c;
   always_comb begin
      legal_c = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
         default:                                legal_c = 1'b0;
      endcase
      trap_c = (DR_EN_i || DWR_EN_i) &&
               (!legal_c ||
                ((funct3_i[1:0] == 2'b01) && ofs_c[0]) ||
                ((funct3_i[1:0] == 2'b10) && (ofs_c != 2'b00)));
   end
`else
   assign trap_c = 1'b0;
`endif

   // store lane enables and lane-replicated write data
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = DT_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_c    = 4'b0001 << ofs_c;
            wdata_c = {4{DT_i[7:0]}};
         end
         2'b01: begin
            be_c    = ofs_c[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{DT_i[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = DT_i;
         end
      endcase
   end

   // load lane extraction and extension
   always_comb begin
      rdata_c   = mem[ld_idx_q];
      shifted_c = rdata_c >> {ld_ofs_q, 3'b000};
      half_c    = ld_ofs_q[1] ? rdata_c[31:16] : rdata_c[15:0];
      case (ld_f3_q[1:0])
         2'b00:   load_data_c = ld_f3_q[2] ? {{(DATAWIDTH-8){1'b0}}, shifted_c[7:0]}
                                           : {{(DATAWIDTH-8){shifted_c[7]}}, shifted_c[7:0]};
         2'b01:   load_data_c = ld_f3_q[2] ? {{(DATAWIDTH-16){1'b0}}, half_c}
                                           : {{(DATAWIDTH-16){half_c[15]}}, half_c};
         default: load_data_c = rdata_c;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ld_idx_d   = ld_idx_q;
      ld_ofs_d   = ld_ofs_q;
      ld_f3_d    = ld_f3_q;
      ld_rd_d    = ld_rd_q;
      ld_rwr_d   = ld_rwr_q;
      wb_valid_d = 1'b0;
      rwr_en_d   = 1'b0;
      rd_d       = rd_q;
      wr_d       = wr_q;
      err_d      = 1'b0;
      mem_we_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && !rst_i) begin
               if (trap_c) begin
                  wb_valid_d = 1'b1;
                  err_d      = 1'b1;
                  wr_d       = result_i;
                  rd_d       = RD_i;
               end else if (DR_EN_i) begin
                  state_d  = ST_LOAD;
                  cnt_d    = CNT_W'(READ_LATENCY - 1);
                  ld_idx_d = idx_c;
                  ld_ofs_d = ofs_c;
                  ld_f3_d  = funct3_i;
                  ld_rd_d  = RD_i;
                  ld_rwr_d = RWR_EN_i;
               end else begin
                  wb_valid_d = 1'b1;
                  wr_d       = result_i;
                  rd_d       = RD_i;
                  rwr_en_d   = RWR_EN_i;
                  mem_we_c   = DWR_EN_i;
               end
            end
         end
         default: begin
            if (cnt_q == '0) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b1;
               wr_d       = load_data_c;
               rd_d       = ld_rd_q;
               rwr_en_d   = ld_rwr_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ld_idx_q   <= '0;
         ld_ofs_q   <= '0;
         ld_f3_q    <= '0;
         ld_rd_q    <= '0;
         ld_rwr_q   <= 1'b0;
         wb_valid_q <= 1'b0;
         rwr_en_q   <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_idx_q   <= ld_idx_d;
         ld_ofs_q   <= ld_ofs_d;
         ld_f3_q    <= ld_f3_d;
         ld_rd_q    <= ld_rd_d;
         ld_rwr_q   <= ld_rwr_d;
         wb_valid_q <= wb_valid_d;
         rwr_en_q   <= rwr_en_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         err_q      <= err_d;
      end
   end

   // memory contents are deliberately not reset
   always_ff @(posedge clk_i) begin
      if (mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
         end
      end
   end

   assign stall_o    = (state_q == ST_LOAD);
   assign wb_valid_o = wb_valid_q;
   assign RWR_EN_o   = rwr_en_q;
   assign RD_o       = rd_q;
   assign WR_o       = wr_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_atomrvcore_dccm_lsu.sv
// Directed, table-driven bench for atomrvcore_dccm_lsu with READ_LATENCY=2.
module tb_atomrvcore_dccm_lsu;

   localparam int unsigned RL = 2;
`ifdef DCCM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i, DWR_EN_i, DR_EN_i, RWR_EN_i;
   logic [31:0] address_i, DT_i, result_i;
   logic [2:0]  funct3_i;
   logic [4:0]  RD_i;
   logic        stall_o, wb_valid_o, RWR_EN_o, err_o;
   logic [4:0]  RD_o;
   logic [31:0] WR_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   atomrvcore_dccm_lsu #(
      .DATAWIDTH(32), .ADDRESS_BUS(10), .REG_ADRESS_WIDTH(5), .READ_LATENCY(RL)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .address_i(address_i),
      .DWR_EN_i(DWR_EN_i), .DR_EN_i(DR_EN_i), .funct3_i(funct3_i), .DT_i(DT_i),
      .RD_i(RD_i), .RWR_EN_i(RWR_EN_i), .result_i(result_i), .stall_o(stall_o),
      .wb_valid_o(wb_valid_o), .RWR_EN_o(RWR_EN_o), .RD_o(RD_o), .WR_o(WR_o), .err_o(err_o)
   );

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] dt;
      logic [4:0]  rd;
      logic        rwr;
      logic [31:0] res;
      int          lat;
      logic [31:0] exp_wr;
      logic        exp_rwr;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] dt,
                               input logic [4:0] rd, input logic rwr, input logic [31:0] res,
                               input int lat, input logic [31:0] exp_wr,
                               input logic exp_rwr, input logic exp_err);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.dt = dt; v.rd = rd;
      v.rwr = rwr; v.res = res; v.lat = lat; v.exp_wr = exp_wr;
      v.exp_rwr = exp_rwr; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic idle_inputs();
      req_valid_i = 1'b0; DWR_EN_i = 1'b0; DR_EN_i = 1'b0; RWR_EN_i = 1'b0;
   endtask

   // called at posedge+1; returns at posedge+1 of the writeback cycle
   task automatic apply(input vec_t v, input int n);
      req_valid_i = 1'b1; DR_EN_i = v.ld; DWR_EN_i = v.st; funct3_i = v.f3;
      address_i = v.addr; DT_i = v.dt; RD_i = v.rd; RWR_EN_i = v.rwr; result_i = v.res;
      @(posedge clk); #1;
      idle_inputs();
      for (int c = 0; c < v.lat; c++) begin
         chk($sformatf("v%0d stall[%0d]", n, c), 32'(stall_o), 32'd1);
         chk($sformatf("v%0d early_wb[%0d]", n, c), 32'(wb_valid_o), 32'd0);
         @(posedge clk); #1;
      end
      chk($sformatf("v%0d stall_end", n), 32'(stall_o), 32'd0);
      chk($sformatf("v%0d wb_valid", n), 32'(wb_valid_o), 32'd1);
      chk($sformatf("v%0d err", n), 32'(err_o), 32'(v.exp_err));
      chk($sformatf("v%0d rwr_en", n), 32'(RWR_EN_o), 32'(v.exp_rwr));
      if (!v.exp_err) begin
         chk($sformatf("v%0d wr", n), WR_o, v.exp_wr);
         chk($sformatf("v%0d rd", n), 32'(RD_o), 32'(v.rd));
      end
   endtask

   initial begin
      // SW/LW/SB/LB/LBU/SH/LH/LHU, aliasing, then misaligned/illegal accesses
      vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 0, 32'h10, 0, 32'h10, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 5'd3, 1, 32'h0, RL, 32'hDEADBEEF, 1, 0));
      vecs.push_back(mk(0, 1, 3'b000, 32'h13, 32'h12345680, 5'd0, 0, 32'h13, 0, 32'h13, 0, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'h13, 32'h0, 5'd4, 1, 32'h0, RL, 32'hFFFFFF80, 1, 0));
      vecs.push_back(mk(1, 0, 3'b100, 32'h13, 32'h0, 5'd4, 1, 32'h0, RL, 32'h00000080, 1, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 5'd6, 1, 32'h0, RL, 32'h80ADBEEF, 1, 0));
      vecs.push_back(mk(0, 1, 3'b001, 32'h12, 32'hABCD1234, 5'd0, 0, 32'h12, 0, 32'h12, 0, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h12, 32'h0, 5'd7, 1, 32'h0, RL, 32'h00001234, 1, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h1012, 32'h0, 5'd7, 1, 32'h0, RL, 32'h00001234, 1, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'hFFFFF010, 32'h0, 5'd8, 1, 32'h0, RL, 32'h1234BEEF, 1, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h20, 32'h0, 5'd0, 0, 32'h20, 0, 32'h20, 0, 0));
      vecs.push_back(mk(0, 1, 3'b001, 32'h20, 32'h00008001, 5'd0, 0, 32'h21, 0, 32'h21, 0, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h20, 32'h0, 5'd9, 1, 32'h0, RL, 32'hFFFF8001, 1, 0));
      vecs.push_back(mk(1, 0, 3'b101, 32'h20, 32'h0, 5'd9, 0, 32'h0, RL, 32'h00008001, 0, 0));
      vecs.push_back(mk(0, 1, 3'b000, 32'h23, 32'h0000007F, 5'd0, 0, 32'h23, 0, 32'h23, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h20, 32'h0, 5'd9, 1, 32'h0, RL, 32'h7F008001, 1, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'h21, 32'h0, 5'd9, 1, 32'h0, RL, 32'hFFFFFF80, 1, 0));
      vecs.push_back(mk(0, 0, 3'b000, 32'h0, 32'h0, 5'd10, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h11, 32'hCAFEF00D, 5'd0, 0, 32'h11, 0, 32'h11, 0, TRAP));
      vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 5'd11, 1, 32'h0, RL,
                        TRAP ? 32'h1234BEEF : 32'hCAFEF00D, 1, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h13, 32'h0, 5'd12, 1, 32'h0, TRAP ? 0 : RL,
                        32'hFFFFCAFE, !TRAP, TRAP));
      vecs.push_back(mk(1, 0, 3'b011, 32'h10, 32'h0, 5'd13, 1, 32'h0, TRAP ? 0 : RL,
                        32'hCAFEF00D, !TRAP, TRAP));
      vecs.push_back(mk(0, 1, 3'b001, 32'h13, 32'h00005555, 5'd0, 0, 32'h13, 0, 32'h13, 0, TRAP));
      vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 5'd14, 1, 32'h0, RL,
                        TRAP ? 32'h1234BEEF : 32'h5555F00D, 1, 0));

      rst_i = 1'b1; idle_inputs();
      funct3_i = 3'b000; address_i = '0; DT_i = '0; RD_i = '0; result_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst stall", 32'(stall_o), 32'd0);
      chk("rst wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst rwr_en", 32'(RWR_EN_o), 32'd0);
      chk("rst rd", 32'(RD_o), 32'd0);
      chk("rst wr", WR_o, 32'd0);
      chk("rst err", 32'(err_o), 32'd0);
      rst_i = 1'b0;

      foreach (vecs[i]) apply(vecs[i], i);

      // back-to-back non-loads, one per cycle
      for (int k = 1; k <= 3; k++) begin
         req_valid_i = 1'b1; RWR_EN_i = 1'b1; RD_i = 5'd5; result_i = 32'(k);
         @(posedge clk); #1;
         chk($sformatf("stream wb[%0d]", k), 32'(wb_valid_o), 32'd1);
         chk($sformatf("stream wr[%0d]", k), WR_o, 32'(k));
         chk($sformatf("stream rd[%0d]", k), 32'(RD_o), 32'd5);
         chk($sformatf("stream stall[%0d]", k), 32'(stall_o), 32'd0);
      end
      idle_inputs();
      @(posedge clk); #1;
      chk("idle wb_valid", 32'(wb_valid_o), 32'd0);
      chk("idle rwr_en", 32'(RWR_EN_o), 32'd0);
      chk("idle wr hold", WR_o, 32'd3);
      chk("idle rd hold", 32'(RD_o), 32'd5);

      // reset during the second stall cycle discards the load
      req_valid_i = 1'b1; DR_EN_i = 1'b1; funct3_i = 3'b010; address_i = 32'h10;
      RD_i = 5'd15; RWR_EN_i = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      chk("mid stall1", 32'(stall_o), 32'd1);
      @(posedge clk); #1;
      chk("mid stall2", 32'(stall_o), 32'd1);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      chk("midrst stall", 32'(stall_o), 32'd0);
      chk("midrst wb_valid", 32'(wb_valid_o), 32'd0);
      chk("midrst rwr_en", 32'(RWR_EN_o), 32'd0);
      chk("midrst rd", 32'(RD_o), 32'd0);
      chk("midrst wr", WR_o, 32'd0);
      chk("midrst err", 32'(err_o), 32'd0);
      req_valid_i = 1'b1; funct3_i = 3'b000; RD_i = 5'd2; RWR_EN_i = 1'b1; result_i = 32'h77;
      @(posedge clk); #1;
      idle_inputs();
      chk("postrst wb_valid", 32'(wb_valid_o), 32'd1);
      chk("postrst wr", WR_o, 32'h77);
      chk("postrst rd", 32'(RD_o), 32'd2);
      @(posedge clk); #1;
      chk("postrst no_late_wb", 32'(wb_valid_o), 32'd0);
      chk("postrst stall", 32'(stall_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
